microwave_cook_timer: RTL and testbench
=======================================

Name: microwave_cook_timer

Overview:
- Countdown engine for the microwave, at the far end of the button master's start/mode/idle interface.
- Accepts keypad digits while idle, then counts MM:SS down once per second while start is high.
- Reports expiry back to the button master on timerEnd, and drives BCD digits for the 7-segment display driver.

Parameters:
- CLK_HZ, 100_000_000, sys_clk cycles per countdown second (bench uses 4).
- PRESET0, 16'h0030, BCD MM:SS loaded on start with no entry when mode=0.
- PRESET1, 16'h0100, same, for mode=1.
- PRESET2, 16'h0200, same, for mode=2.
- PRESET3, 16'h0500, same, for mode=3.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- sys_rst  in  1  synchronous, active-high reset.
- mini_rst  in  1  synchronous clear/abort (keypad clear); lower priority than sys_rst.
- start  in  1  level from the button master; high = cook requested.
- mode  in  2  power mode from the button master; selects the preset.
- digit_valid  in  1  one-cycle strobe from the keyboard decoder.
- digit  in  4  keypad code; 0-9 are digits, 4'hA is the start key.
- timerEnd  out  1  one-cycle pulse when the countdown reaches 00:00.
- running  out  1  high in RUN.
- time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}.

Behaviour:
- Reset: sys_rst forces state IDLE, time_bcd=0, prescaler=0, timerEnd=0, running=0, start edge register=0.
- mini_rst has the same effect as sys_rst. sys_rst wins if both are asserted.
- States are IDLE, RUN, PAUSE, DONE. Start edges are taken from a registered copy of start.
- IDLE, digit entry:
  - digit_valid with digit<=9 shifts left: time_bcd <= {time_bcd[11:0], digit}. The oldest digit drops out.
  - Codes above 9 are ignored.
  - Seconds fields up to 99 are accepted (1:90 is legal).
- IDLE, start rising edge:
  - If time_bcd==0, load PRESETn selected by mode.
  - Clear the prescaler and go to RUN the next cycle.
- RUN:
  - running=1.
  - The prescaler counts 0..CLK_HZ-1. At terminal count, decrement time_bcd by one second.
- Decrement rules:
  - sec_ones>0: decrement sec_ones.
  - Otherwise sec_tens>0: sec_tens-1, sec_ones=9.
  - Otherwise borrow a minute (min_ones-1, or min_tens-1 with min_ones=9) and set seconds to 59.
  - So 1:90 counts 90 s, then 0:59 onward.
- Expiry:
  - When a decrement produces 00:00, pulse timerEnd for exactly one cycle, coincident with the first cycle of DONE.
  - Expiry occurs CLK_HZ*N cycles after entering RUN with N seconds loaded.
- RUN, start falling edge: go to PAUSE. Hold time_bcd and the prescaler value; running=0.
- RUN and PAUSE ignore digits, except as set out under Optional Feature.
- PAUSE: start rising edge returns to RUN and continues from the held prescaler. mini_rst clears as in reset.
- DONE: hold 00:00 and running=0. Leave for IDLE when start is low (start may already be low on entry).
- Simultaneous events:
  - A start falling edge in the same cycle as the final tick: expiry wins. timerEnd pulses and the state goes to DONE.
  - digit_valid in the same cycle as a start rising edge in IDLE: the digit is accepted first, and the zero check uses the updated value.

Optional Feature:
- Macro: COOK_TIMER_ADD30_EN.
- Defined:
  - In RUN or PAUSE, digit_valid with digit==4'hA adds 30 s, with BCD carry into minutes.
  - The result saturates at 99:59.
  - If this coincides with a tick, apply the decrement first, then the add.
- Undefined: 4'hA is ignored in every state. No add logic is synthesized.

Decomposition:
- Package cook_timer_pkg:
  - State enum (IDLE/RUN/PAUSE/DONE).
  - KEY_START=4'hA.
  - BCD MM:SS struct/typedef.
  - Function bcd_dec_sec.
  - Function bcd_add30_sat.
- One sub-module, cook_prescaler: the CLK_HZ counter with clear, hold and tick output.

Test Plan:
- Entry shift: sys_rst, digits 1,2,3,4 strobed -> time_bcd=16'h1234. Digit 4'hB ignored. Fifth digit 5 -> 16'h2345.
- Preset: time_bcd=0, mode=2, start rises -> time_bcd=16'h0200, running=1 within 2 cycles. First decrement after 4 clocks -> 16'h0159.
- Expiry: enter 0,3, start high -> timerEnd high for exactly one cycle at 12 clocks post-RUN, time_bcd=0, state DONE. Drop start -> IDLE.
- Non-normalized entry: enter 1,9,0 (1:90), run 91 ticks -> time_bcd=16'h0059.
- Pause/resume/abort: run 0:10 for 3 ticks, drop start -> 16'h0007 frozen for 20 clocks. Raise start -> resumes to 0006. mini_rst -> time_bcd=0, IDLE, no timerEnd.
- ADD30 (macro defined): in RUN at 0:45, strobe 4'hA -> 16'h0115. At 99:50 -> 16'h9959. Macro undefined -> unchanged.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared types and BCD helpers for the microwave cook timer.
// The add-30 helper is only used when COOK_TIMER_ADD30_EN is defined.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_START = 4'hA;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // Seconds fields may hold up to 99, so only a zero seconds field borrows a minute.
  function automatic bcd_time_t bcd_dec_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else if (t.sec_tens != 4'd0) begin
      r.sec_tens = t.sec_tens - 4'd1;
      r.sec_ones = 4'd9;
    end else if (t.min_ones != 4'd0) begin
      r.min_ones = t.min_ones - 4'd1;
      r.sec_tens = 4'd5;
      r.sec_ones = 4'd9;
    end else if (t.min_tens != 4'd0) begin
      r.min_tens = t.min_tens - 4'd1;
      r.min_ones = 4'd9;
      r.sec_tens = 4'd5;
      r.sec_ones = 4'd9;
    end
    return r;
  endfunction

  function automatic bcd_time_t bcd_add30_sat(input bcd_time_t t);
    bcd_time_t  r;
    logic [4:0] tens;
    logic [4:0] wrapped;
    r       = t;
    tens    = {1'b0, t.sec_tens} + 5'd3;
    wrapped = tens - 5'd6;
    if (tens < 5'd6) begin
      r.sec_tens = tens[3:0];
    end else if (t.min_tens == 4'd9 && t.min_ones == 4'd9) begin
      r = bcd_time_t'(16'h9959);
    end else begin
      r.sec_tens = wrapped[3:0];
      if (t.min_ones == 4'd9) begin
        r.min_tens = t.min_tens + 4'd1;
        r.min_ones = 4'd0;
      end else begin
        r.min_ones = t.min_ones + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_cook_timer_if.sv
// Button-master / keypad side of the cook timer; master drives requests, slave reports time.
interface microwave_cook_timer_if;
  logic        start;
  logic [1:0]  mode;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        timerEnd;
  logic        running;
  logic [15:0] time_bcd;

  modport master (
    output start, mode, digit_valid, digit,
    input  timerEnd, running, time_bcd
  );

  modport slave (
    input  start, mode, digit_valid, digit,
    output timerEnd, running, time_bcd
  );
endinterface

// File: rtl/cook_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, holds otherwise, ticks at terminal count.
module cook_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_cook_timer.sv
// MM:SS countdown engine: keypad entry in IDLE, per-second countdown in RUN, pause and expiry.
// Define COOK_TIMER_ADD30_EN to let the start key add 30 s while cooking or paused.
module microwave_cook_timer
  import cook_timer_pkg::*;
#(
  parameter int          CLK_HZ  = 100_000_000,
  parameter logic [15:0] PRESET0 = 16'h0030,
  parameter logic [15:0] PRESET1 = 16'h0100,
  parameter logic [15:0] PRESET2 = 16'h0200,
  parameter logic [15:0] PRESET3 = 16'h0500
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  input logic                  mini_rst,
  microwave_cook_timer_if.slave bus
);

  state_e    state;
  bcd_time_t time_q;
  logic      start_q;
  logic      timer_end_q;

  logic      clear_all;
  logic      start_rise;
  logic      start_fall;
  logic      digit_ok;
  logic      tick;
  logic      presc_clear;
  bcd_time_t entered;
  bcd_time_t dec_time;
  bcd_time_t run_time;
  bcd_time_t held_next;
  bcd_time_t preset;

  assign clear_all   = sys_rst || mini_rst;
  assign start_rise  = bus.start && !start_q;
  assign start_fall  = !bus.start && start_q;
  assign digit_ok    = bus.digit_valid && (bus.digit <= 4'd9);
  assign entered     = digit_ok ? bcd_time_t'({time_q[11:0], bus.digit}) : time_q;
  assign dec_time    = bcd_dec_sec(time_q);
  assign run_time    = tick ? dec_time : time_q;
  // Counter only carries a partial second across RUN/PAUSE; everywhere else it sits at zero.
  assign presc_clear = (state == IDLE) || (state == DONE);

`ifdef COOK_TIMER_ADD30_EN
  assign held_next = (bus.digit_valid && bus.digit == KEY_START) ? bcd_add30_sat(run_time)
                                                                 : run_time;
`else
  assign held_next = run_time;
`endif

  always_comb begin
    preset = bcd_time_t'(PRESET0);
    case (bus.mode)
      2'd0:    preset = bcd_time_t'(PRESET0);
      2'd1:    preset = bcd_time_t'(PRESET1);
      2'd2:    preset = bcd_time_t'(PRESET2);
      default: preset = bcd_time_t'(PRESET3);
    endcase
  end

  cook_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (clear_all),
    .clear   (presc_clear),
    .enable  (state == RUN),
    .tick    (tick)
  );

  // Expiry takes precedence over a start falling edge in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (clear_all) begin
      state       <= IDLE;
      time_q      <= '0;
      start_q     <= 1'b0;
      timer_end_q <= 1'b0;
    end else begin
      start_q     <= bus.start;
      timer_end_q <= 1'b0;
      case (state)
        IDLE: begin
          time_q <= entered;
          if (start_rise) begin
            state <= RUN;
            if (entered == '0) time_q <= preset;
          end
        end
        RUN: begin
          time_q <= held_next;
          if (tick && dec_time == '0) begin
            state       <= DONE;
            time_q      <= '0;
            timer_end_q <= 1'b1;
          end else if (start_fall) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          time_q <= held_next;
          if (start_rise) state <= RUN;
        end
        DONE: begin
          time_q <= '0;
          if (!bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timerEnd = timer_end_q;
  assign bus.running  = (state == RUN);
  assign bus.time_bcd = time_q;

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Directed bench for microwave_cook_timer with a 4-cycle second; expectations follow COOK_TIMER_ADD30_EN.
module tb_microwave_cook_timer;
  import cook_timer_pkg::*;

  localparam int CLK_HZ = 4;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic mini_rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  microwave_cook_timer_if bus ();

  microwave_cook_timer #(.CLK_HZ(CLK_HZ)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mini_rst (mini_rst),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    @(negedge sys_clk);
    bus.digit_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic doReset();
    bus.start = 1'b0;
    sys_rst   = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
  endtask

  initial begin
    sys_rst         = 1'b1;
    mini_rst        = 1'b0;
    bus.start       = 1'b0;
    bus.mode        = 2'd0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    waitCycles(2);
    checkOutput("reset_time", bus.time_bcd, 16'h0000);
    checkOutput("reset_running", {15'd0, bus.running}, 16'd0);
    checkOutput("reset_timerEnd", {15'd0, bus.timerEnd}, 16'd0);
    sys_rst = 1'b0;

    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    checkOutput("entry_1234", bus.time_bcd, 16'h1234);
    applyStimulus(4'hB);
    checkOutput("entry_ignore_B", bus.time_bcd, 16'h1234);
    applyStimulus(KEY_START);
    checkOutput("entry_ignore_A", bus.time_bcd, 16'h1234);
    applyStimulus(4'd5);
    checkOutput("entry_shift_2345", bus.time_bcd, 16'h2345);

    doReset();
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    waitCycles(1);
    checkOutput("preset2_load", bus.time_bcd, 16'h0200);
    checkOutput("preset2_running", {15'd0, bus.running}, 16'd1);
    waitCycles(3);
    checkOutput("preset2_before_tick", bus.time_bcd, 16'h0200);
    waitCycles(1);
    checkOutput("preset2_first_dec", bus.time_bcd, 16'h0159);
    bus.start = 1'b0;
    waitCycles(1);
    checkOutput("preset2_paused", {15'd0, bus.running}, 16'd0);

    doReset();
    bus.mode  = 2'd3;
    bus.start = 1'b1;
    waitCycles(1);
    checkOutput("preset3_load", bus.time_bcd, 16'h0500);

    doReset();
    bus.mode        = 2'd0;
    bus.digit_valid = 1'b1;
    bus.digit       = 4'd7;
    bus.start       = 1'b1;
    waitCycles(1);
    bus.digit_valid = 1'b0;
    checkOutput("digit_with_start", bus.time_bcd, 16'h0007);
    checkOutput("digit_with_start_run", {15'd0, bus.running}, 16'd1);
    waitCycles(4);
    checkOutput("digit_with_start_dec", bus.time_bcd, 16'h0006);

    doReset();
    applyStimulus(4'd0);
    applyStimulus(4'd3);
    checkOutput("expiry_entry", bus.time_bcd, 16'h0003);
    bus.start = 1'b1;
    waitCycles(12);
    checkOutput("expiry_pre_time", bus.time_bcd, 16'h0001);
    checkOutput("expiry_pre_end", {15'd0, bus.timerEnd}, 16'd0);
    waitCycles(1);
    checkOutput("expiry_end_pulse", {15'd0, bus.timerEnd}, 16'd1);
    checkOutput("expiry_time_zero", bus.time_bcd, 16'h0000);
    checkOutput("expiry_not_running", {15'd0, bus.running}, 16'd0);
    waitCycles(1);
    checkOutput("expiry_pulse_once", {15'd0, bus.timerEnd}, 16'd0);
    applyStimulus(4'd8);
    checkOutput("done_ignores_digit", bus.time_bcd, 16'h0000);
    bus.start = 1'b0;
    waitCycles(1);
    applyStimulus(4'd7);
    checkOutput("done_to_idle", bus.time_bcd, 16'h0007);

    doReset();
    applyStimulus(4'd1);
    bus.start = 1'b1;
    waitCycles(4);
    bus.start = 1'b0;
    waitCycles(1);
    checkOutput("fall_tick_end", {15'd0, bus.timerEnd}, 16'd1);
    checkOutput("fall_tick_time", bus.time_bcd, 16'h0000);
    waitCycles(1);
    applyStimulus(4'd2);
    checkOutput("fall_tick_idle", bus.time_bcd, 16'h0002);

    doReset();
    applyStimulus(4'd1);
    applyStimulus(4'd9);
    applyStimulus(4'd0);
    checkOutput("nonnorm_entry", bus.time_bcd, 16'h0190);
    bus.start = 1'b1;
    waitCycles(361);
    checkOutput("nonnorm_90_ticks", bus.time_bcd, 16'h0100);
    waitCycles(4);
    checkOutput("nonnorm_91_ticks", bus.time_bcd, 16'h0059);
    bus.start = 1'b0;

    doReset();
    applyStimulus(4'd1);
    applyStimulus(4'd0);
    bus.start = 1'b1;
    waitCycles(13);
    checkOutput("pause_3_ticks", bus.time_bcd, 16'h0007);
    bus.start = 1'b0;
    waitCycles(1);
    checkOutput("pause_running_low", {15'd0, bus.running}, 16'd0);
    applyStimulus(4'd3);
    waitCycles(19);
    checkOutput("pause_frozen", bus.time_bcd, 16'h0007);
    bus.start = 1'b1;
    waitCycles(3);
    checkOutput("resume_running", {15'd0, bus.running}, 16'd1);
    checkOutput("resume_before_tick", bus.time_bcd, 16'h0007);
    waitCycles(1);
    checkOutput("resume_tick", bus.time_bcd, 16'h0006);
    mini_rst  = 1'b1;
    bus.start = 1'b0;
    waitCycles(1);
    mini_rst  = 1'b0;
    checkOutput("abort_time", bus.time_bcd, 16'h0000);
    checkOutput("abort_running", {15'd0, bus.running}, 16'd0);
    checkOutput("abort_no_end", {15'd0, bus.timerEnd}, 16'd0);
    applyStimulus(4'd4);
    checkOutput("abort_idle_entry", bus.time_bcd, 16'h0004);

    doReset();
    applyStimulus(4'd4);
    applyStimulus(4'd5);
    bus.start = 1'b1;
    waitCycles(2);
    applyStimulus(KEY_START);
`ifdef COOK_TIMER_ADD30_EN
    checkOutput("add30_0045", bus.time_bcd, 16'h0115);
`else
    checkOutput("add30_0045", bus.time_bcd, 16'h0045);
`endif

    doReset();
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    applyStimulus(4'd5);
    applyStimulus(4'd0);
    bus.start = 1'b1;
    waitCycles(2);
    applyStimulus(KEY_START);
`ifdef COOK_TIMER_ADD30_EN
    checkOutput("add30_sat", bus.time_bcd, 16'h9959);
`else
    checkOutput("add30_sat", bus.time_bcd, 16'h9950);
`endif
    doReset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
